// File: rtl/excess3_pkg.sv
// Shared constants and the buffered result type for the Excess-3 to BCD decoder.
package excess3_pkg;

  localparam logic [3:0] E3_OFFSET   = 4'd3;
  localparam logic [3:0] E3_MIN      = 4'b0011;
  localparam logic [3:0] E3_MAX      = 4'b1100;
  localparam logic [3:0] BCD_INVALID = 4'b1111;
  localparam int         FIFO_DEPTH  = 2;

  // One buffered decode result: error flag alongside the BCD digit.
  typedef struct packed {
    logic       err;
    logic [3:0] bcd;
  } result_t;

endpackage

// File: rtl/excess3_digit_dec.sv
// Purely combinational single-digit Excess-3 to BCD decoder.
module excess3_digit_dec
  import excess3_pkg::*;
(
  input  logic [3:0] code,
  output logic [3:0] bcd,
  output logic       err
);

  // Codes inside the Excess-3 window subtract the offset; anything else is flagged.
  always_comb begin
    bcd = BCD_INVALID;
    err = 1'b1;
    if ((code >= E3_MIN) && (code <= E3_MAX)) begin
      bcd = code - E3_OFFSET;
      err = 1'b0;
    end
  end

endmodule

// File: rtl/excess3_to_bcd.sv
// Excess-3 to BCD decoder with a 2-entry result FIFO and a saturating
// counter of accepted invalid codes.
module excess3_to_bcd
  import excess3_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [3:0]       din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic [3:0]       dout,
  output logic             dout_err,
  output logic             dout_valid,
  input  logic             dout_ready,
  input  logic             err_clr,
  output logic [CNT_W-1:0] err_cnt
);

  localparam logic [1:0]       DEPTH   = 2'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [3:0] dec_bcd;
  logic       dec_err;
  result_t    mem [FIFO_DEPTH];
  result_t    last_q;
  result_t    head;
  logic [1:0] count;
  logic       rd_ptr;
  logic       wr_ptr;
  logic       push;
  logic       pop;

  excess3_digit_dec u_dec (
    .code (din),
    .bcd  (dec_bcd),
    .err  (dec_err)
  );

  // Acceptance never looks at the consumer side, so a full buffer blocks
  // input even on a cycle where the head is being popped.
  assign din_ready  = en && (count < DEPTH) && !rst;
  assign push       = din_valid && din_ready;
  assign dout_valid = (count != 2'd0);
  assign pop        = dout_valid && dout_ready;

  // When empty the output shows the most recently popped result.
  assign head     = dout_valid ? mem[rd_ptr] : last_q;
  assign dout     = head.bcd;
  assign dout_err = head.err;

  // FIFO storage, pointers and occupancy; a pop also latches the head as the held value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      last_q <= '0;
      count  <= 2'd0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= '{err: dec_err, bcd: dec_bcd};
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        last_q <= mem[rd_ptr];
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Saturating count of accepted invalid codes; a clear still records a coincident error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt <= '0;
    end else if (err_clr) begin
      err_cnt <= (push && dec_err) ? CNT_W'(1) : '0;
    end else if (push && dec_err && (err_cnt != CNT_MAX)) begin
      err_cnt <= err_cnt + CNT_W'(1);
    end
  end

endmodule
